ga_fitness_algo: RTL and testbench

GA_FITNESS_ALGO -- requirements
Module: ga_fitness_algo

---
 rtl/ga_fitness_algo.sv | 128 ++++++++++++
 tb/tb_ga_fitness_algo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ga_fitness_algo.sv
// ga_fitness_algo: scores a chromosome against data vectors by counting
// matching bits (XNOR popcount), one SLICE_W-bit slice per cycle, and
// accumulates the score into a saturating fitness register.
module ga_fitness_algo #(
    parameter int CHROM_W = 32,
    parameter int SLICE_W = 8,
    parameter int FIT_W   = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               sw_rst,
    input  logic               fit_flush_pls,
    input  logic               fit_start_pls,
    input  logic               fit_next_pls,
    input  logic [CHROM_W-1:0] chrom_in,
    input  logic [CHROM_W-1:0] vd_buff_rd_data,
    output logic               algo_done_pls,
    output logic               algo_busy,
    output logic [FIT_W-1:0]   fit_res
);
    localparam int N     = CHROM_W / SLICE_W;
    localparam int PS_W  = $clog2(CHROM_W + 1);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    // Wide enough for fit_res + partial sum without overflow.
    localparam int SUM_W = (FIT_W + 1 > PS_W + 1) ? FIT_W + 1 : PS_W + 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(N - 1);
    localparam logic [SUM_W-1:0] FIT_MAX = {{(SUM_W - FIT_W){1'b0}}, {FIT_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [CHROM_W-1:0] chrom_r, vec_r;
    logic [CNT_W-1:0]   slice_cnt;
    logic [PS_W-1:0]    psum;
    logic [PS_W-1:0]    psum_nxt;
    logic [SLICE_W-1:0] slice_match;
    logic [PS_W-1:0]    slice_pc;
    logic [SUM_W-1:0]   fit_sum;
    logic [FIT_W-1:0]   fit_sat;
    logic               go;

    // A start/next only counts when no flush accompanies it.
    assign go        = (fit_start_pls | fit_next_pls) & ~fit_flush_pls;
    assign algo_busy = (state != IDLE);

    // Select the current slice of the match vector and popcount it; the
    // final slice's count is folded straight into the saturating add so
    // the result lands in the same cycle as the done pulse.
    always_comb begin
        logic [CHROM_W-1:0] match_v;
        match_v     = ~(chrom_r ^ vec_r);
        slice_match = '0;
        for (int k = 0; k < N; k++)
            if (slice_cnt == CNT_W'(k))
                slice_match = match_v[k*SLICE_W +: SLICE_W];
        slice_pc = '0;
        for (int i = 0; i < SLICE_W; i++)
            slice_pc = slice_pc + PS_W'(slice_match[i]);
        psum_nxt = psum + slice_pc;
        fit_sum  = SUM_W'(fit_res) + SUM_W'(psum_nxt);
        fit_sat  = (fit_sum > FIT_MAX) ? {FIT_W{1'b1}} : fit_sum[FIT_W-1:0];
    end

    // State register; soft reset has priority over every pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       state <= IDLE;
        else if (sw_rst) state <= IDLE;
        else             state <= state_nxt;
    end

    // Next-state logic; a flush returns to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        if (fit_flush_pls) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (go) state_nxt = CALC;
                CALC:    if (slice_cnt == LAST) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: chromosome/vector capture, slice walk, fitness accumulate.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chrom_r       <= '0;
            vec_r         <= '0;
            slice_cnt     <= '0;
            psum          <= '0;
            fit_res       <= '0;
            algo_done_pls <= 1'b0;
        end else if (sw_rst) begin
            chrom_r       <= '0;
            vec_r         <= '0;
            slice_cnt     <= '0;
            psum          <= '0;
            fit_res       <= '0;
            algo_done_pls <= 1'b0;
        end else if (fit_flush_pls) begin
            chrom_r       <= chrom_in;
            slice_cnt     <= '0;
            psum          <= '0;
            fit_res       <= '0;
            algo_done_pls <= 1'b0;
        end else begin
            algo_done_pls <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    vec_r     <= vd_buff_rd_data;
                    slice_cnt <= '0;
                    psum      <= '0;
                end
                CALC: begin
                    psum      <= psum_nxt;
                    slice_cnt <= slice_cnt + 1'b1;
                    if (slice_cnt == LAST) begin
                        fit_res       <= fit_sat;
                        algo_done_pls <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ga_fitness_algo.sv
// Bench for ga_fitness_algo: two instances (FIT_W=16 and FIT_W=6) share
// stimulus; a transaction-level model predicts done/busy/fitness per cycle.
module tb_ga_fitness_algo;
    localparam int CW = 32;
    localparam int SW = 8;
    localparam int N  = CW / SW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          sw_rst = 1'b0;
    logic          flush = 1'b0, start = 1'b0, nxt = 1'b0;
    logic [CW-1:0] chrom_in = '0, vec = '0;
    logic          done16, busy16, done6, busy6;
    logic [15:0]   fit16;
    logic [5:0]    fit6;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    ga_fitness_algo #(.CHROM_W(CW), .SLICE_W(SW), .FIT_W(16)) dut16 (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .fit_flush_pls(flush),
        .fit_start_pls(start), .fit_next_pls(nxt), .chrom_in(chrom_in),
        .vd_buff_rd_data(vec), .algo_done_pls(done16), .algo_busy(busy16),
        .fit_res(fit16));

    ga_fitness_algo #(.CHROM_W(CW), .SLICE_W(SW), .FIT_W(6)) dut6 (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .fit_flush_pls(flush),
        .fit_start_pls(start), .fit_next_pls(nxt), .chrom_in(chrom_in),
        .vd_buff_rd_data(vec), .algo_done_pls(done6), .algo_busy(busy6),
        .fit_res(fit6));

    // Model: chromosome, two fitness accumulators, and a countdown of the
    // cycles left in the current evaluation (N+1 busy cycles, last = done).
    logic [CW-1:0] m_chrom = '0;
    int            m_fit16 = 0, m_fit6 = 0, m_rem = 0, m_match = 0;

    task automatic model_clear();
        m_chrom = '0; m_fit16 = 0; m_fit6 = 0; m_rem = 0;
    endtask

    always @(negedge rstn) model_clear();

    always @(posedge clk) begin
        if (!rstn || sw_rst) begin
            model_clear();
        end else if (flush) begin
            m_chrom = chrom_in; m_fit16 = 0; m_fit6 = 0; m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 1) begin
                m_fit16 = (m_fit16 + m_match > 65535) ? 65535 : m_fit16 + m_match;
                m_fit6  = (m_fit6 + m_match > 63) ? 63 : m_fit6 + m_match;
            end
        end else if (start || nxt) begin
            m_match = $countones(~(m_chrom ^ vec));
            m_rem   = N + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) if (cmp_en) begin
        chk("done16", int'(done16), int'(m_rem == 1));
        chk("busy16", int'(busy16), int'(m_rem > 0));
        chk("fit16",  int'(fit16),  m_fit16);
        chk("done6",  int'(done6),  int'(m_rem == 1));
        chk("busy6",  int'(busy6),  int'(m_rem > 0));
        chk("fit6",   int'(fit6),   m_fit6);
    end

    // One cycle of stimulus, launched just after the rising edge.
    task automatic drive(input logic f, input logic s, input logic n, input logic sr,
                         input logic [CW-1:0] c, input logic [CW-1:0] v);
        @(posedge clk); #2;
        flush = f; start = s; nxt = n; sw_rst = sr; chrom_in = c; vec = v;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(0, 0, 0, 0, '0, '0);
    endtask

    initial begin
        #12;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_fit", int'(fit16), 0);
        chk("reset_busy", int'(busy16), 0);
        rstn = 1'b1;
        idle(2);

        // Basic match count and accumulation.
        drive(1, 0, 0, 0, 32'hFFFF0000, '0);
        drive(0, 1, 0, 0, '0, 32'hFFFF0000);
        idle(6);
        chk("lit_fit_32", int'(fit16), 32);
        chk("lit_model_32", m_fit16, 32);
        drive(0, 0, 1, 0, '0, 32'h0000FFFF);
        idle(6);
        chk("lit_fit_nomatch", int'(fit16), 32);
        drive(0, 0, 1, 0, '0, 32'hFFFF00FF);
        idle(6);
        chk("lit_fit_56", int'(fit16), 56);

        // Saturation: FIT_W=6 clamps at 63 while FIT_W=16 keeps counting.
        drive(1, 0, 0, 0, 32'h12345678, '0);
        for (int r = 0; r < 3; r++) begin
            drive(0, 0, 1, 0, '0, 32'h12345678);
            idle(6);
        end
        chk("lit_fit16_96", int'(fit16), 96);
        chk("lit_fit6_sat", int'(fit6), 63);

        // Start during an evaluation is ignored.
        drive(1, 0, 0, 0, 32'hA5A5A5A5, '0);
        drive(0, 1, 0, 0, '0, 32'hA5A5A5A5);
        idle(1);
        drive(0, 1, 0, 0, '0, 32'h00000000);
        idle(6);
        chk("lit_ignore_start", int'(fit16), 32);

        // Flush together with start: flush wins, no evaluation.
        drive(1, 1, 0, 0, 32'h0F0F0F0F, 32'h0F0F0F0F);
        @(posedge clk); #1;
        chk("lit_flush_start_busy", int'(busy16), 0);

        // Flush mid-evaluation aborts without a done pulse.
        drive(0, 1, 0, 0, '0, 32'h0F0F0F0F);
        idle(2);
        drive(1, 0, 0, 0, 32'h0000FFFF, '0);
        @(posedge clk); #1;
        chk("lit_flush_busy", int'(busy16), 0);
        chk("lit_flush_fit", int'(fit16), 0);
        chk("lit_flush_done", int'(done16), 0);

        // Soft reset mid-evaluation: same, and chromosome cleared to 0.
        drive(0, 1, 0, 0, '0, 32'h0000FFFF);
        idle(2);
        drive(0, 0, 0, 1, '0, '0);
        @(posedge clk); #1;
        chk("lit_swrst_busy", int'(busy16), 0);
        drive(0, 1, 0, 0, '0, 32'h00000000);
        idle(6);
        chk("lit_swrst_chrom0", int'(fit16), 32);

        // Async reset mid-CALC clears outputs without waiting for a clock.
        drive(0, 0, 1, 0, '0, 32'hFFFFFFFF);
        idle(2);
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        chk("lit_arst_busy", int'(busy16), 0);
        chk("lit_arst_done", int'(done16), 0);
        chk("lit_arst_fit", int'(fit16), 0);
        @(posedge clk); #3;
        rstn = 1'b1;
        drive(0, 1, 0, 0, '0, 32'h0000000F);
        idle(6);
        chk("lit_after_arst", int'(fit16), 28);

        idle(2);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
